// File: rtl/lsu_router_if.sv
// Core/L1 load-store bus for lsu_router.
// The master drives core requests and L1 responses; the slave is the router.
interface lsu_router_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 10
);
  logic              load_control;
  logic              store_control;
  logic [N-1:0]      addr;
  logic [N-1:0]      wdata;
  logic [N-1:0]      rdata;
  logic              stall;
  logic              l1_load_control;
  logic              l1_store_control;
  logic [ADDR_W-1:0] l1_address;
  logic [N-1:0]      l1_wdata;
  logic              l1_ack;
  logic [N-1:0]      l1_rdata;

  modport master (
    output load_control, store_control, addr, wdata, l1_ack, l1_rdata,
    input  rdata, stall, l1_load_control, l1_store_control, l1_address, l1_wdata
  );

  modport slave (
    input  load_control, store_control, addr, wdata, l1_ack, l1_rdata,
    output rdata, stall, l1_load_control, l1_store_control, l1_address, l1_wdata
  );
endinterface

// File: rtl/lsu_router.sv
// Load/store router: stack scratchpad (zero-stall) or L1 via registered req/ack FSM.
// Latency: scratchpad 0 cycles; L1 >= 3 cycles, stall held until the DONE cycle.
// Backpressure: stall freezes the core; optional LSU_POSTED_STORE_EN lets L1 stores retire at once.
module lsu_router #(
  parameter int N      = 32,
  parameter int ADDR_W = 10,
  parameter int SPM_AW = 4
) (
  input logic        clk,
  input logic        reset,
  lsu_router_if.slave bus
);

`ifdef LSU_POSTED_STORE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, POSTED = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state_q, state_d;

  logic [ADDR_W-1:0] word_addr;
  logic              in_spm;
  logic              l1_access;
  logic              spm_we;
  logic [N-1:0]      spm_rdata;
  logic [N-1:0]      spm_mem [0:(1<<SPM_AW)-1];

  logic              req_ld_q, req_st_q;
  logic [ADDR_W-1:0] addr_q;
  logic [N-1:0]      wdata_q;
  logic [N-1:0]      resp_q;
  logic              stall;
  logic [N-1:0]      rdata;

  // Byte offset and bits above the L1 word address are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[1:0], bus.addr[N-1:ADDR_W+2]};

  assign word_addr = bus.addr[ADDR_W+1:2];
  assign in_spm    = (word_addr >> SPM_AW) == '0;
  assign l1_access = (bus.load_control | bus.store_control) & ~in_spm;

`ifdef LSU_POSTED_STORE_EN
  assign spm_we = bus.store_control & in_spm & ((state_q == IDLE) | (state_q == POSTED));
`else
  assign spm_we = bus.store_control & in_spm & (state_q == IDLE);
`endif

  assign spm_rdata = spm_mem[word_addr[SPM_AW-1:0]];

  always_ff @(posedge clk) begin
    if (spm_we) spm_mem[word_addr[SPM_AW-1:0]] <= bus.wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (l1_access) begin
`ifdef LSU_POSTED_STORE_EN
          state_d = bus.store_control ? POSTED : BUSY;
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY:    if (bus.l1_ack) state_d = DONE;
      // The core still presents the retiring access here; never re-launch it.
      DONE:    state_d = IDLE;
`ifdef LSU_POSTED_STORE_EN
      POSTED:  if (bus.l1_ack) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    rdata = spm_rdata;
    case (state_q)
`ifdef LSU_POSTED_STORE_EN
      IDLE:   stall = l1_access & ~bus.store_control;
      POSTED: stall = l1_access;
`else
      IDLE:   stall = l1_access;
`endif
      BUSY:   stall = 1'b1;
      DONE:   rdata = resp_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ld_q <= 1'b0;
      req_st_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resp_q   <= '0;
    end else begin
      if (state_q == IDLE && l1_access) begin
        req_ld_q <= ~bus.store_control;
        req_st_q <= bus.store_control;
        addr_q   <= word_addr;
        wdata_q  <= bus.wdata;
`ifdef LSU_POSTED_STORE_EN
      end else if (bus.l1_ack && (state_q == BUSY || state_q == POSTED)) begin
`else
      end else if (bus.l1_ack && state_q == BUSY) begin
`endif
        req_ld_q <= 1'b0;
        req_st_q <= 1'b0;
      end
      if (state_q == BUSY && bus.l1_ack) resp_q <= bus.l1_rdata;
    end
  end

  assign bus.stall            = stall;
  assign bus.rdata            = rdata;
  assign bus.l1_load_control  = req_ld_q;
  assign bus.l1_store_control = req_st_q;
  assign bus.l1_address       = addr_q;
  assign bus.l1_wdata         = wdata_q;

endmodule
